// File: rtl/uart_rx_if.sv
// Serial-receive bundle: line and parity configuration in, received word and status out.
// The master side drives the line; the slave side is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  Par_en;
    logic                  Par_typ;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  Busy;

    modport master (
        output RX_IN, Par_en, Par_typ,
        input  P_DATA, Data_valid, par_err, stp_err, Busy
    );

    modport slave (
        input  RX_IN, Par_en, Par_typ,
        output P_DATA, Data_valid, par_err, stp_err, Busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-voted bit sampling, optional parity,
// single-cycle valid/error pulses issued at the stop-bit decision point.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LO  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_DEC = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state, next_state;
    logic                  rx_meta, rx_s;
    logic [CW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  s_lo, s_mid;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH:0]   shift_ext;
    logic                  par_en_q, par_typ_q, par_flag;
    logic                  decide, bit_end, bit_val;

    assign decide    = (edge_cnt == CNT_DEC);
    assign bit_end   = (edge_cnt == CNT_END);
    assign bit_val   = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign shift_ext = {bit_val, shift_reg};
    assign bus.Busy  = (state != IDLE);

    // Synchronizer resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            rx_meta <= bus.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (decide && bit_val) next_state = IDLE;
                     else if (bit_end)      next_state = DATA;
            DATA:    if (bit_end && bit_cnt == BIT_LAST)
                         next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (decide) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data word is reset as well, since P_DATA must read zero out of reset.
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            s_lo           <= 1'b1;
            s_mid          <= 1'b1;
            shift_reg      <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_flag       <= 1'b0;
            bus.P_DATA     <= '0;
            bus.Data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
        end else begin
            bus.Data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;

            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (!rx_s) begin
                    par_en_q  <= bus.Par_en;
                    par_typ_q <= bus.Par_typ;
                    par_flag  <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + CW'(1);
                if (edge_cnt == CNT_LO)  s_lo  <= rx_s;
                if (edge_cnt == CNT_MID) s_mid <= rx_s;
            end

            case (state)
                DATA: begin
                    if (decide) shift_reg <= shift_ext[DATA_WIDTH:1];
                    if (bit_end) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                end
                PARITY: begin
                    if (decide) par_flag <= bit_val ^ (^shift_reg) ^ par_typ_q;
                end
                STOP: begin
                    // A low stop bit outranks a parity error; only a clean frame updates P_DATA.
                    if (decide) begin
                        if (!bit_val)      bus.stp_err <= 1'b1;
                        else if (par_flag) bus.par_err <= 1'b1;
                        else begin
                            bus.P_DATA     <= shift_reg;
                            bus.Data_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: expected responses are queued as frames are driven
// and matched by a negedge monitor against each output pulse.
module tb_uart_rx;
    localparam int DW = 8;
    localparam int OS = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef enum {EV_DATA, EV_PAR, EV_STP} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] model_pdata = '0;
    ev_t           mon_e;
    ev_kind_e      mon_k;
    int            mon_n;
    int            prev_n = 0;

    // Response monitor: every pulse must match the head of the scoreboard; P_DATA must hold otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            model_pdata = '0;
            prev_n      = 0;
        end else begin
            mon_n = int'(bus.Data_valid) + int'(bus.par_err) + int'(bus.stp_err);
            if (mon_n != 0) begin
                n_cmp++;
                if (mon_n != 1 || prev_n != 0) begin
                    n_err++;
                    $display("FAIL pulse_shape: got dv=%b pe=%b se=%b prev=%0d, required exactly one single-cycle pulse",
                             bus.Data_valid, bus.par_err, bus.stp_err, prev_n);
                end else if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got dv=%b pe=%b se=%b, required no pulse",
                             bus.Data_valid, bus.par_err, bus.stp_err);
                end else begin
                    mon_e = sb.pop_front();
                    mon_k = bus.Data_valid ? EV_DATA : (bus.par_err ? EV_PAR : EV_STP);
                    n_cmp++;
                    if (mon_k != mon_e.kind) begin
                        n_err++;
                        $display("FAIL pulse_kind: got %s, required %s", mon_k.name(), mon_e.kind.name());
                    end else if (mon_k == EV_DATA) begin
                        if (bus.P_DATA !== mon_e.data) begin
                            n_err++;
                            $display("FAIL p_data: got %h, required %h", bus.P_DATA, mon_e.data);
                        end
                        model_pdata = mon_e.data;
                    end
                end
            end
            if (!bus.Data_valid) begin
                n_cmp++;
                if (bus.P_DATA !== model_pdata) begin
                    n_err++;
                    $display("FAIL p_data_hold: got %h, required %h", bus.P_DATA, model_pdata);
                end
            end
            prev_n = mon_n;
        end
    end

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.RX_IN = b;
        repeat (OS) @(negedge clk);
    endtask

    // Drives one frame; flip_par corrupts the parity bit, mid_change toggles the config after the start bit.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop, input logic mid_change);
        ev_t  e;
        logic pb;
        bus.Par_en  = pen;
        bus.Par_typ = ptyp;
        pb = (^d) ^ ptyp ^ flip_par;
        e.data = d;
        if (!stop)                e.kind = EV_STP;
        else if (pen && flip_par) e.kind = EV_PAR;
        else                      e.kind = EV_DATA;
        sb.push_back(e);
        send_bit(1'b0);
        if (mid_change) begin
            bus.Par_en  = ~pen;
            bus.Par_typ = ~ptyp;
        end
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (pen) send_bit(pb);
        send_bit(stop);
        bus.RX_IN = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * OS && sb.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.RX_IN   = 1'b1;
        bus.Par_en  = 1'b0;
        bus.Par_typ = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (bus.P_DATA !== '0)       begin n_err++; $display("FAIL rst_p_data: got %h, required 00", bus.P_DATA); end
        if (bus.Data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv: got %b, required 0", bus.Data_valid); end
        if (bus.par_err !== 1'b0)    begin n_err++; $display("FAIL rst_par_err: got %b, required 0", bus.par_err); end
        if (bus.stp_err !== 1'b0)    begin n_err++; $display("FAIL rst_stp_err: got %b, required 0", bus.stp_err); end
        if (bus.Busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b, required 0", bus.Busy); end
        rst = 1'b1;
        idle(2 * OS);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(OS);
        n_cmp += 3;
        if (sb.size() != 0)       begin n_err++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
        if (bus.Busy !== 1'b0)    begin n_err++; $display("FAIL basic_busy: got %b, required 0", bus.Busy); end
        if (bus.P_DATA !== 8'hA5) begin n_err++; $display("FAIL basic_p_data: got %h, required a5", bus.P_DATA); end
    endtask

    task automatic test_parity();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(OS);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL parity_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'h3C) begin n_err++; $display("FAIL parity_hold: got %h, required 3c", bus.P_DATA); end
        send_frame(8'hB7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(OS);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL odd_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'hB7) begin n_err++; $display("FAIL odd_p_data: got %h, required b7", bus.P_DATA); end
    endtask

    task automatic test_stop_err();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2 * OS);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL stop_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'h0F) begin n_err++; $display("FAIL stop_p_data: got %h, required 0f", bus.P_DATA); end
    endtask

    task automatic test_glitch();
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_hi: got %b, required 1", bus.Busy); end
        idle(OS);
        n_cmp++;
        if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_lo: got %b, required 0", bus.Busy); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL glitch_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'h81) begin n_err++; $display("FAIL glitch_p_data: got %h, required 81", bus.P_DATA); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'h34) begin n_err++; $display("FAIL b2b_p_data: got %h, required 34", bus.P_DATA); end
    endtask

    task automatic test_param_change();
        // Parity frame whose parity bit is 0: dropping Par_en mid-frame must not make it a stop bit.
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL cfg_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'h66) begin n_err++; $display("FAIL cfg_p_data: got %h, required 66", bus.P_DATA); end
    endtask

    task automatic test_reset_abort();
        logic [DW-1:0] d;
        d = 8'h9E;
        bus.Par_en = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        bus.RX_IN = d[4];
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre: got %b, required 1", bus.Busy); end
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.Busy !== 1'b0)    begin n_err++; $display("FAIL abort_busy: got %b, required 0", bus.Busy); end
        if (bus.P_DATA !== '0)    begin n_err++; $display("FAIL abort_p_data: got %h, required 00", bus.P_DATA); end
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2 * OS);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(OS);
        n_cmp += 2;
        if (sb.size() != 0)       begin n_err++; $display("FAIL abort_drain: got %0d pending, required 0", sb.size()); end
        if (bus.P_DATA !== 8'hC3) begin n_err++; $display("FAIL abort_new_p_data: got %h, required c3", bus.P_DATA); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_param_change();
        test_reset_abort();
        idle(2 * OS);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL timeout: simulation exceeded 50000 cycles, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 8, clk cycles per bit; legal values are even and at least 4.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port RX_IN  input  1  serial line; idles high; asynchronous to clk.
REQ-006 Port Par_en  input  1  1 = frame carries a parity bit.
REQ-007 Port Par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 Port P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-009 Port Data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 Port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 Port stp_err  output  1  one-cycle pulse on a low stop bit.
REQ-012 Port Busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-014 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-015 The edge counter SHALL count 0..OVERSAMPLE-1 within each bit, wrap to 0 at the end of the bit, and be cleared on entry to START.
REQ-016 The bit value SHALL be the majority vote of rx_s sampled at edge counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-017 The bit decision SHALL be made at edge count OVERSAMPLE/2+1 (the decision cycle).
REQ-018 IDLE -> START SHALL occur on the first cycle rx_s=0; Par_en and Par_typ SHALL be captured on this transition.
REQ-019 At the START decision cycle: bit=0 -> remain in START until the bit ends, then go to DATA; bit=1 -> return to IDLE at once (glitch), with no output pulses.
REQ-020 DATA SHALL receive DATA_WIDTH bits LSB first into a shift register.
REQ-021 After the last data bit ends, the FSM SHALL go to PARITY if the captured Par_en=1, else to STOP.
REQ-022 In PARITY, the sampled bit SHALL be compared against XOR(data) XOR captured Par_typ; a mismatch sets an internal error flag.
REQ-023 At the STOP decision cycle, the FSM SHALL return to IDLE so that a back-to-back start edge is caught; the rest of the stop bit is not waited out.
REQ-024 At the STOP decision cycle, exactly one response SHALL occur on the next cycle:
 - stop bit=0 -> pulse stp_err;
 - else, parity flag set -> pulse par_err;
 - else -> load P_DATA and pulse Data_valid.
REQ-025 P_DATA SHALL change only when Data_valid pulses and otherwise hold its value.
REQ-026 par_err, stp_err and Data_valid SHALL be mutually exclusive and SHALL each be high for exactly 1 cycle.
REQ-027 Par_en and Par_typ changes mid-frame SHALL NOT affect the frame in progress.
REQ-028 A line held low after a stop error SHALL be treated as a new start bit.

Reset
REQ-029 While rst=0, the block SHALL hold: state=IDLE, counters=0, P_DATA=0, Data_valid=0, par_err=0, stp_err=0, Busy=0, synchronizer flops=1.
REQ-030 Assertion of rst mid-frame SHALL abort the frame immediately with no output pulse.
REQ-031 After reset release, the first frame SHALL be received correctly.

Verification (OVERSAMPLE=8, DATA_WIDTH=8)
REQ-032 Par_en=0, frame 0xA5 (start 0, 1,0,1,0,0,1,0,1, stop 1) -> P_DATA=0xA5, one Data_valid pulse, no error pulses, Busy low after the stop decision cycle.
REQ-033 Par_en=1, Par_typ=0, 0x3C with parity 0 -> P_DATA=0x3C and Data_valid pulse; same frame with parity 1 -> par_err pulse, P_DATA keeps 0x3C from the earlier frame, no Data_valid.
REQ-034 Frame 0x55 with stop bit 0 -> stp_err pulse only, P_DATA unchanged; a following valid frame 0x0F -> P_DATA=0x0F.
REQ-035 RX_IN low for 2 clk then high -> FSM returns to IDLE with no output pulses; next valid frame 0x81 -> P_DATA=0x81.
REQ-036 Two frames back-to-back, each with a 1-bit stop, 0x12 then 0x34 -> two Data_valid pulses with P_DATA 0x12 then 0x34.
REQ-037 rst=0 during data bit 4, then released, then frame 0xC3 -> no pulse from the aborted frame; P_DATA=0xC3 after the new frame.
